// File: rtl/m_arith_pkg.sv
// Shared definitions for the EX-stage arithmetic library.
//   div_state_t : control states of the sequential divider
//   MAX_W       : widest operand the helpers below accept
//   DIV_ZERO_Q  : quotient reported for a zero divisor (all ones)
//   abs_n()     : two's-complement magnitude of a zero-extended operand
package m_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int MAX_W = 64;

  localparam logic [MAX_W-1:0] DIV_ZERO_Q = '1;

  // The caller supplies the sign (it knows the real operand width) and
  // truncates the result back to that width. The low N bits of the
  // MAX_W-wide negation equal the N-bit two's-complement negation, so
  // abs(MIN) = 2^(N-1) comes out correctly as an unsigned magnitude.
  function automatic logic [MAX_W-1:0] abs_n(input logic [MAX_W-1:0] v,
                                             input logic             neg);
    return neg ? -v : v;
  endfunction

endpackage

// File: rtl/m_div_step.sv
// One combinational radix-2 restoring division iteration.
//   r      : partial remainder in (always < d on entry)
//   q      : quotient / dividend shift register in
//   d      : divisor magnitude
//   r_next : partial remainder after the step
//   q_next : shift register after the step, new quotient bit in bit 0
module m_div_step #(
  parameter int N = 32
) (
  input  logic [N-1:0] r,
  input  logic [N-1:0] q,
  input  logic [N-1:0] d,
  output logic [N-1:0] r_next,
  output logic [N-1:0] q_next
);

  logic [N:0] shifted;
  logic [N:0] trial;

  // {R,Q} << 1: the dividend MSB moves into the remainder. The trial
  // subtract keeps one extra bit so its top bit is a clean borrow flag.
  assign shifted = {r, q[N-1]};
  assign trial   = shifted - {1'b0, d};

  // On a borrow the pre-shift remainder was < d, so shifted[N] is zero and
  // dropping it loses nothing.
  assign r_next = trial[N] ? shifted[N-1:0] : trial[N-1:0];
  assign q_next = {q[N-2:0], ~trial[N]};

endmodule

// File: rtl/m_seq_divider.sv
// Iterative radix-2 restoring divider for MIPS DIV/DIVU.
// One quotient bit per clock; fixed latency of N+1 cycles from start.
//   clk, rst    : clock, synchronous active-high reset
//   start       : launch request, accepted in IDLE or DONE
//   is_signed   : 1 = two's-complement operands, 0 = unsigned
//   dividend    : numerator, sampled with start
//   divisor     : denominator, sampled with start
//   busy        : operation in progress
//   done        : one-cycle pulse, results valid
//   quotient    : LO result, held until the next DONE
//   remainder   : HI result, held until the next DONE
//   div_by_zero : held result came from a zero divisor
module m_seq_divider
  import m_arith_pkg::*;
#(
  parameter  int N  = 32,
  localparam int CW = $clog2(N+1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         is_signed,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  div_state_t    state, state_nxt;
  logic [CW-1:0] cnt;
  logic [N-1:0]  r_reg, q_reg, d_reg;
  logic [N-1:0]  r_step, q_step;
  logic          q_neg, r_neg, dz;
  logic          neg_dvd, neg_dsr;
  logic [N-1:0]  mag_dvd, mag_dsr;
  logic          accept, last;

  assign neg_dvd = is_signed & dividend[N-1];
  assign neg_dsr = is_signed & divisor[N-1];
  assign mag_dvd = N'(abs_n(MAX_W'(dividend), neg_dvd));
  assign mag_dsr = N'(abs_n(MAX_W'(divisor), neg_dsr));

  // A request is taken whenever no division is in flight; in DONE this
  // gives back-to-back operation without an IDLE bubble.
  assign accept = start && (state != RUN);
  assign last   = (state == RUN) && (cnt == CW'(1));

  assign busy = (state == RUN);
  assign done = (state == DONE);

  m_div_step #(.N(N)) u_step (
    .r      (r_reg),
    .q      (q_reg),
    .d      (d_reg),
    .r_next (r_step),
    .q_next (q_step)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt == CW'(1)) state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control and visible results: cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_nxt;
      if (last) begin
        quotient <= dz ? N'(DIV_ZERO_Q) : (q_neg ? -q_step : q_step);
        // With a zero divisor every trial succeeds, so the partial remainder
        // ends as |dividend| and the sign fix-up restores the original
        // dividend in both modes.
        remainder   <= r_neg ? -r_step : r_step;
        div_by_zero <= dz;
      end
    end
  end

  // Working registers: only meaningful while RUN, so no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      r_reg <= '0;
      q_reg <= mag_dvd;
      d_reg <= mag_dsr;
      q_neg <= neg_dvd ^ neg_dsr;
      r_neg <= neg_dvd;
      dz    <= (divisor == '0);
      cnt   <= CW'(N);
    end else if (state == RUN) begin
      r_reg <= r_step;
      q_reg <= q_step;
      cnt   <= cnt - CW'(1);
    end
  end

endmodule

// File: tb/tb_m_seq_divider.sv
// Self-checking bench for m_seq_divider (N=32): directed cases from the
// DIV/DIVU behaviour plus randomized operands against an arithmetic model.
module tb_m_seq_divider;

  logic        clk;
  logic        rst;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int vectors     = 0;
  int miscompares = 0;

  m_seq_divider #(.N(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: DIV/DIVU semantics with plain 64-bit arithmetic.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                input logic s, output logic [31:0] q,
                                output logic [31:0] r, output logic z);
    longint sa, sb, sq, sr;
    z = (b == 32'd0);
    if (z) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      sq = sa / sb;
      sr = sa % sb;
      q  = sq[31:0];
      r  = sr[31:0];
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; presents a request for exactly one edge.
  task automatic launch(input logic [31:0] a, input logic [31:0] b,
                        input logic s);
    start     = 1'b1;
    dividend  = a;
    divisor   = b;
    is_signed = s;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called in cycle E0+1; returns at the negedge of the DONE cycle.
  // A nonzero poke pulses start with altered operands in that RUN cycle.
  task automatic wait_check(input logic [31:0] a, input logic [31:0] b,
                            input logic s, input string tag, input int poke);
    int cyc, busy_cnt;
    logic [31:0] eq, er;
    logic ez;
    model(a, b, s, eq, er, ez);
    cyc = 1;
    busy_cnt = 0;
    while (done !== 1'b1 && cyc < 100) begin
      if (busy === 1'b1) busy_cnt++;
      start = (cyc == poke);
      if (cyc == poke) begin
        dividend = ~a;
        divisor  = 32'd3;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk({tag, ".latency"}, 32'(cyc), 32'd33);
    chk({tag, ".busy_cycles"}, 32'(busy_cnt), 32'd32);
    chk({tag, ".done"}, 32'(done), 32'd1);
    chk({tag, ".quotient"}, quotient, eq);
    chk({tag, ".remainder"}, remainder, er);
    chk({tag, ".div_by_zero"}, 32'(div_by_zero), 32'(ez));
  endtask

  initial begin
    logic [31:0] a, b, hq, hr;
    logic        s, hz;
    rst = 1'b1; start = 1'b0; is_signed = 1'b0;
    dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.done", 32'(done), 32'd0);
    chk("reset.quotient", quotient, 32'd0);
    chk("reset.remainder", remainder, 32'd0);
    chk("reset.dz", 32'(div_by_zero), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    launch(32'd100, 32'd7, 1'b0);
    wait_check(32'd100, 32'd7, 1'b0, "u100_7", 0);
    @(negedge clk);

    launch(32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_check(32'hFFFF_FFF9, 32'd2, 1'b1, "s-7_2", 0);
    chk("s-7_2.q_const", quotient, 32'hFFFF_FFFD);
    chk("s-7_2.r_const", remainder, 32'hFFFF_FFFF);
    @(negedge clk);

    launch(32'd7, 32'hFFFF_FFFE, 1'b1);
    wait_check(32'd7, 32'hFFFF_FFFE, 1'b1, "s7_-2", 0);
    chk("s7_-2.r_const", remainder, 32'd1);
    @(negedge clk);

    launch(32'h1234_5678, 32'd0, 1'b0);
    wait_check(32'h1234_5678, 32'd0, 1'b0, "dz_u", 0);
    @(negedge clk);
    launch(32'h1234_5678, 32'd0, 1'b1);
    wait_check(32'h1234_5678, 32'd0, 1'b1, "dz_s", 0);
    @(negedge clk);
    launch(32'h8765_4321, 32'd0, 1'b1);
    wait_check(32'h8765_4321, 32'd0, 1'b1, "dz_sneg", 0);
    @(negedge clk);

    launch(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_check(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "ovf_s", 0);
    chk("ovf_s.q_const", quotient, 32'h8000_0000);
    @(negedge clk);
    launch(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_check(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "ovf_u", 0);
    chk("ovf_u.r_const", remainder, 32'h8000_0000);
    @(negedge clk);

    // start mid-RUN is ignored
    launch(32'd1000, 32'd33, 1'b0);
    wait_check(32'd1000, 32'd33, 1'b0, "poke", 10);

    // back-to-back: request in the DONE cycle
    launch(32'hFFFF_FF00, 32'd16, 1'b1);
    wait_check(32'hFFFF_FF00, 32'd16, 1'b1, "b2b", 0);

    // results hold through IDLE
    model(32'hFFFF_FF00, 32'd16, 1'b1, hq, hr, hz);
    repeat (5) @(negedge clk);
    chk("hold.busy", 32'(busy), 32'd0);
    chk("hold.done", 32'(done), 32'd0);
    chk("hold.quotient", quotient, hq);
    chk("hold.remainder", remainder, hr);

    // reset in cycle 15 of a divide
    launch(32'hDEAD_BEEF, 32'h13, 1'b0);
    repeat (13) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid.busy", 32'(busy), 32'd0);
    chk("rstmid.done", 32'(done), 32'd0);
    chk("rstmid.quotient", quotient, 32'd0);
    chk("rstmid.remainder", remainder, 32'd0);
    chk("rstmid.dz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    chk("rstmid.still_idle", 32'(busy), 32'd0);
    launch(32'd9, 32'd3, 1'b0);
    wait_check(32'd9, 32'd3, 1'b0, "after_rst", 0);
    @(negedge clk);

    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = (($urandom_range(0, 1)) != 0) ? 32'hFFFF_FFFF : 32'h8000_0000;
        3:       b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      if (i % 4 == 0) a = 32'h8000_0000;
      launch(a, b, s);
      wait_check(a, b, s, $sformatf("rnd%0d", i), 0);
      if ($urandom_range(0, 1) == 0) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/m_seq_divider.md
Name: m_seq_divider

Overview:
- Iterative radix-2 restoring divider; the inverse operation of the combinational array multiplier in the EX-stage arithmetic library.
- Serves MIPS DIV/DIVU: the EX stage launches it with a one-cycle start, stalls on busy, and writes HI/LO from the result on done.
- Computes one quotient bit per clock, so a division completes with a fixed latency independent of operand values.

Parameters:
N, 32, operand/result width in bits (N >= 2)
CW, $clog2(N+1), iteration counter width (derived; not overridden)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  launch request; sampled only when idle or done
is_signed  input  1  1 = two's-complement (DIV), 0 = unsigned (DIVU); sampled with start
dividend  input  N  numerator; sampled with start
divisor  input  N  denominator; sampled with start
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse: results valid this cycle
quotient  output  N  quotient (LO); held until the next accepted start
remainder  output  N  remainder (HI); held until the next accepted start
div_by_zero  output  1  divisor was zero for the held result

Behaviour:
- Reset (rst=1 at a clk edge), from any state including mid-operation:
  - state <- IDLE.
  - busy, done, quotient, remainder and div_by_zero all <- 0.
  - Any in-flight operation is discarded.
- States: IDLE, RUN, DONE.
- IDLE:
  - If start=1, latch operands, the sign flags, and the zero-divisor flag; counter <- N; go to RUN.
  - Otherwise stay in IDLE.
- Operand conditioning on accept:
  - Unsigned mode: magnitudes are the raw operands.
  - Signed mode: take the absolute value of each operand; note that abs(MIN) = 2^(N-1) fits in N bits unsigned.
  - Record q_neg = sign(dividend) XOR sign(divisor), and r_neg = sign(dividend).
- RUN, one restoring step per cycle:
  - {R,Q} shifts left by 1, with R the partial remainder and Q the quotient register.
  - trial = R - D, computed N+1 bits wide.
  - If trial is non-negative: R <- trial and Q[0] <- 1. Otherwise R is unchanged and Q[0] <- 0.
  - Counter decrements; after the Nth step go to DONE.
- DONE (exactly one cycle):
  - done=1 and busy=0.
  - quotient = q_neg ? -Q : Q.
  - remainder = r_neg ? -R : R.
  - Outputs update on the edge entering DONE.
  - Next state is RUN if start=1 (back-to-back accept), else IDLE.
- Latency:
  - start sampled at edge E0.
  - busy=1 during cycles E0+1 .. E0+N.
  - done=1 in cycle E0+N+1.
  - Total: N+1 cycles from start to result.
- start while RUN: ignored; no queuing, and the operation in progress is unaffected.
- Divide by zero:
  - Latency is unchanged (same state sequence).
  - Results are forced at DONE: quotient = all ones, remainder = the original dividend (sign-preserved), div_by_zero=1.
- Signed overflow (MIN / -1): the natural result is quotient = MIN, remainder = 0; no flag, no special casing.
- Width rules:
  - Internal subtract is N+1 bits to avoid losing the borrow.
  - Negation is two's complement, N bits, with wrap permitted.
- Outputs hold their last DONE values through IDLE; they clear only on reset.

Decomposition:
- Shared package m_arith_pkg:
  - div_state_t enum {IDLE, RUN, DONE}.
  - Constant DIV_ZERO_Q = all ones.
  - Helper function abs_n.
- Sub-module m_div_step: purely combinational single restoring iteration.
  - Inputs: R, Q, D.
  - Outputs: next R, next Q.
  - Instantiated once in the datapath; also unit-testable standalone.

Test Plan:
- Unsigned, N=32: dividend=100, divisor=7, is_signed=0 -> done in cycle 33 after start; quotient=14, remainder=2, div_by_zero=0; busy high exactly 32 cycles.
- Signed, N=32: dividend=-7 (0xFFFFFFF9), divisor=2 -> quotient=-3 (0xFFFFFFFD), remainder=-1 (0xFFFFFFFF); and 7/-2 -> quotient=0xFFFFFFFD, remainder=1.
- Divide by zero: dividend=0x12345678, divisor=0, either mode -> quotient=0xFFFFFFFF, remainder=0x12345678, div_by_zero=1, same 33-cycle latency.
- Signed overflow: 0x80000000 / 0xFFFFFFFF, is_signed=1 -> quotient=0x80000000, remainder=0; unsigned mode on the same operands -> quotient=0, remainder=0x80000000.
- Handshake:
  - start pulsed mid-RUN (cycle 10) -> ignored; the first result is unchanged.
  - start asserted in the DONE cycle -> accepted; second done exactly 33 cycles later.
  - Outputs hold during IDLE.
- Reset mid-operation: rst=1 at cycle 15 of a divide -> next cycle busy=0, done=0, quotient=0, remainder=0; a subsequent 9/3 yields quotient=3, remainder=0.
